// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Replace only the bytes whose enable bit is set.
    function automatic logic [WORD_W-1:0] be_merge(
        input logic [WORD_W-1:0] oldWord,
        input logic [WORD_W-1:0] newWord,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] merged;
        merged = oldWord;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = newWord[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with byte write enables; load data registered on the access edge.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= be_merge(r_mem[addr], wdata, be);
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory target with programmable wait states.
// Optional misaligned-access flagging is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic                r_rspValid;
    logic                r_rspLoad;
    logic                r_rspErr;

    logic                w_accept;
    logic                w_access;
    logic                w_accWe;
    logic [ADDR_W-1:0]   w_accAddr;
    logic [WORD_W-1:0]   w_accWdata;
    logic [BE_W-1:0]     w_accBe;
    logic                w_accErr;
    logic [WORD_W-1:0]   w_ramRdata;

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    // With no wait states the access uses the live request on the accept edge.
    always_comb begin
        w_access   = 1'b0;
        w_accWe    = r_we;
        w_accAddr  = r_addr;
        w_accWdata = r_wdata;
        w_accBe    = r_be;
        if (WAIT_CYCLES == 0) begin
            w_access   = w_accept;
            w_accWe    = req_we;
            w_accAddr  = req_addr;
            w_accWdata = req_wdata;
            w_accBe    = req_be;
        end else begin
            w_access = (r_state == WAIT) && (r_cnt == 4'd0) && !rst;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_accErr = (w_accAddr[1:0] != 2'b00);
`else
    logic w_unused;
    assign w_accErr = 1'b0;
    assign w_unused = ^w_accAddr[1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_rspValid <= 1'b0;
            r_rspLoad  <= 1'b0;
            r_rspErr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        r_cnt   <= CNT_INIT;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state    <= IDLE;
                        r_rspValid <= 1'b0;
                        r_rspLoad  <= 1'b0;
                        r_rspErr   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // The access edge always hands over to the response phase.
            if (w_access) begin
                r_state    <= RESP;
                r_rspValid <= 1'b1;
                r_rspLoad  <= !w_accWe && !w_accErr;
                r_rspErr   <= w_accErr;
            end
        end
    end

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (ADDR_W - 2)
    ) u_ram (
        .clk   (clk),
        .en    (w_access && !w_accErr),
        .we    (w_accWe),
        .addr  (w_accAddr[ADDR_W-1:2]),
        .wdata (w_accWdata),
        .be    (w_accBe),
        .rdata (w_ramRdata)
    );

    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspLoad ? w_ramRdata : '0;
    assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with two wait states.
module tb_dmem_responder;

    localparam int ADDR_W  = 9;
    localparam int DEPTH   = 128;
    localparam int WAITS   = 2;
    localparam int TIMEOUT = 50;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // Drives a request until it is accepted; returns #1 after the accept edge with inputs scrambled.
    task automatic issueReq(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be, output bit ok);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (!req_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        if (ok) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        req_be    = ~be;
    endtask

    // Full transaction with rsp_ready high; latency is -1 when nothing came back in time.
    task automatic doTransaction(input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 output logic [31:0] rdata, output logic err, output int latency);
        bit ok;
        int n;
        rsp_ready = 1'b1;
        latency   = -1;
        rdata     = 'x;
        err       = 1'bx;
        issueReq(we, addr, wdata, be, ok);
        if (!ok) return;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < TIMEOUT);
        if (rsp_valid) begin
            latency = n;
            rdata   = rsp_rdata;
            err     = rsp_err;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (req_ready !== 1'b0)
            $display("[TB] FAIL reset_ready_low: got %b want 0", req_ready);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        compared++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_idle: got ready=%b valid=%b rdata=%h err=%b want 1 0 00000000 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_store_load;
        logic [31:0] rd;
        logic        er;
        int          lat;
        doTransaction(1'b1, 9'h010, 32'hDEADBEEF, 4'hF, rd, er, lat);
        compared++;
        if (lat !== WAITS + 1 || rd !== 32'h0 || er !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL store_full: got lat=%0d rdata=%h err=%b want %0d 00000000 0", lat, rd, er, WAITS + 1);
        end
        doTransaction(1'b0, 9'h010, 32'h0, 4'h0, rd, er, lat);
        compared++;
        if (lat !== WAITS + 1 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL load_full: got lat=%0d rdata=%h err=%b want %0d deadbeef 0", lat, rd, er, WAITS + 1);
        end
    endtask

    task automatic test_be_merge;
        logic [31:0] rd;
        logic        er;
        int          lat;
        doTransaction(1'b1, 9'h020, 32'h11223344, 4'hF, rd, er, lat);
        doTransaction(1'b1, 9'h020, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        compared++;
        if (lat !== WAITS + 1 || rd !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL store_partial: got lat=%0d rdata=%h want %0d 00000000", lat, rd, WAITS + 1);
        end
        doTransaction(1'b0, 9'h020, 32'h0, 4'h0, rd, er, lat);
        compared++;
        if (rd !== 32'h11BB33DD) begin
            mismatched++;
            $display("[TB] FAIL be_merge: got %h want 11bb33dd", rd);
        end
        doTransaction(1'b1, 9'h020, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        compared++;
        if (lat !== WAITS + 1) begin
            mismatched++;
            $display("[TB] FAIL be_zero_rsp: got lat=%0d want %0d", lat, WAITS + 1);
        end
        doTransaction(1'b0, 9'h020, 32'h0, 4'hF, rd, er, lat);
        compared++;
        if (rd !== 32'h11BB33DD) begin
            mismatched++;
            $display("[TB] FAIL be_zero_nochange: got %h want 11bb33dd", rd);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int n;
        rsp_ready = 1'b0;
        issueReq(1'b0, 9'h020, 32'h0, 4'hF, ok);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < TIMEOUT);
        compared++;
        if (n !== WAITS + 1 || !ok) begin
            mismatched++;
            $display("[TB] FAIL bp_latency: got %0d want %0d", n, WAITS + 1);
        end
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11BB33DD || req_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b rdata=%h ready=%b want 1 11bb33dd 0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_release: got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          ok;
        doTransaction(1'b1, 9'h030, 32'h0, 4'hF, rd, er, lat);
        // Reset during the first wait cycle, then during the last one.
        for (int variant = 0; variant < 2; variant++) begin
            issueReq(1'b1, 9'h030, 32'h12345678, 4'hF, ok);
            if (variant == 1) begin
                @(posedge clk);
                #1;
            end
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                compared++;
                if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL wait_rst_idle%0d: got valid=%b ready=%b want 0 1", variant, rsp_valid, req_ready);
                end
            end
            doTransaction(1'b0, 9'h030, 32'h0, 4'hF, rd, er, lat);
            compared++;
            if (rd !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL wait_rst_nostore%0d: got %h want 00000000", variant, rd);
            end
        end
    endtask

    task automatic test_reset_in_resp;
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          ok;
        rsp_ready = 1'b0;
        issueReq(1'b1, 9'h034, 32'hCAFEF00D, 4'hF, ok);
        repeat (WAITS + 2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        compared++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL resp_rst_drop: got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
        end
        doTransaction(1'b0, 9'h034, 32'h0, 4'hF, rd, er, lat);
        compared++;
        if (rd !== 32'hCAFEF00D) begin
            mismatched++;
            $display("[TB] FAIL resp_rst_committed: got %h want cafef00d", rd);
        end
    endtask

    task automatic test_low_addr_bits;
        logic [31:0] rd;
        logic        er;
        int          lat;
`ifdef DMEM_ALIGN_CHECK_EN
        doTransaction(1'b1, 9'h040, 32'h5A5A0001, 4'hF, rd, er, lat);
        doTransaction(1'b1, 9'h041, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        compared++;
        if (er !== 1'b1 || lat !== WAITS + 1 || rd !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL misaligned_store: got err=%b lat=%0d rdata=%h want 1 %0d 00000000", er, lat, rd, WAITS + 1);
        end
        doTransaction(1'b0, 9'h042, 32'h0, 4'hF, rd, er, lat);
        compared++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL misaligned_load: got err=%b rdata=%h want 1 00000000", er, rd);
        end
        doTransaction(1'b0, 9'h040, 32'h0, 4'hF, rd, er, lat);
        compared++;
        if (er !== 1'b0 || rd !== 32'h5A5A0001) begin
            mismatched++;
            $display("[TB] FAIL misaligned_nowrite: got err=%b rdata=%h want 0 5a5a0001", er, rd);
        end
`else
        doTransaction(1'b0, 9'h013, 32'h0, 4'h1, rd, er, lat);
        compared++;
        if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            mismatched++;
            $display("[TB] FAIL low_bits_ignored: got err=%b rdata=%h want 0 deadbeef", er, rd);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int accepts[$];
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 9'h010;
        req_wdata = 32'h0;
        req_be    = 4'hF;
        for (int c = 0; c < 14; c++) begin
            if (req_ready) accepts.push_back(c);
            if (rsp_valid) begin
                compared++;
                if (rsp_rdata !== 32'hDEADBEEF) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_data: got %h want deadbeef", rsp_rdata);
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (WAITS + 3) @(negedge clk);
        compared++;
        if (accepts.size() !== 4) begin
            mismatched++;
            $display("[TB] FAIL b2b_count: got %0d want 4", accepts.size());
        end else begin
            compared++;
            if (accepts[1] - accepts[0] !== WAITS + 2 || accepts[3] - accepts[2] !== WAITS + 2) begin
                mismatched++;
                $display("[TB] FAIL b2b_spacing: got %0d,%0d want %0d", accepts[1] - accepts[0],
                         accepts[3] - accepts[2], WAITS + 2);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_store_load();
        test_be_merge();
        test_backpressure();
        test_reset_in_wait();
        test_reset_in_resp();
        test_low_addr_bits();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory target that serves load/store requests issued by the CPU core's memory stage.
- Uses a valid/ready request/response handshake.
- Inserts a programmable number of wait states.
- Supports byte-enable writes into an internal word-organised RAM.
- Replaces the zero-latency combinational data memory, so the core can later be stalled by a realistic memory.

Parameters:
- ADDR_W, 9, byte-address width; must be ≥ 3.
- DEPTH, 128, number of 32-bit words; equals 2^(ADDR_W-2).
- WAIT_CYCLES, 2, wait states inserted between request accept and memory access; range 0..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address; word index is req_addr[ADDR_W-1:2].
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i selects wdata[8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load data; 0 for stores.
- rsp_err  out  1  access error (only with the optional feature; otherwise tied 0).

Behaviour:
- Reset (sync, active-high): state = IDLE, wait counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, captured request registers = 0. RAM contents are not reset.
- req_ready = 1 only in state IDLE and only when rst = 0. It is a combinational function of state only and does not depend on req_valid.
- States:
  - IDLE → WAIT on accept (req_valid & req_ready), when WAIT_CYCLES > 0. On accept, capture we, addr, wdata and be, and load counter = WAIT_CYCLES-1.
  - IDLE → RESP directly on accept, when WAIT_CYCLES = 0. The memory access happens on the accept edge.
  - WAIT: counter decrements each cycle. When counter = 0, the access is performed on that edge and the state moves to RESP.
  - RESP: rsp_valid = 1. Hold rsp_rdata and rsp_err stable until rsp_ready = 1, then go to IDLE on that edge.
- Access rules:
  - Store: for each i with be[i] = 1, RAM[word][8i+7:8i] ← wdata byte i. Bytes with be[i] = 0 are unchanged. rsp_rdata = 0.
  - Store with be = 0000: no RAM change; a response is still returned.
  - Load: rsp_rdata = the full 32-bit word, regardless of be.
  - addr[1:0] is ignored unless the optional feature is enabled.
- Latency: accept on edge T → rsp_valid high in the cycle after edge T+WAIT_CYCLES (i.e. first visible after edge T+WAIT_CYCLES+1 counted from accept cycle = 1). With WAIT_CYCLES = 2, a request accepted at cycle 0 gives rsp_valid at cycle 3.
- Throughput: one transaction outstanding at most. Minimum spacing between accepts is WAIT_CYCLES + 2 cycles (with rsp_ready held high).
- Response and request in the same cycle: the request is not accepted in RESP, because req_ready = 0. It is accepted in the following IDLE cycle.
- Read-after-write to the same word: the second access sees the stored data, since only one transaction is ever outstanding.
- Reset mid-operation:
  - In WAIT, the transaction is dropped and a store is not performed.
  - In RESP, the response is dropped. A store has already been committed.
- The request inputs are sampled only on the accept edge. Changes to them afterwards are ignored.

Optional Feature:
Macro: DMEM_ALIGN_CHECK_EN.
- When defined, an accepted request with req_addr[1:0] ≠ 00 is flagged misaligned. For a flagged request:
  - no RAM read or write takes place;
  - the response carries rsp_err = 1 and rsp_rdata = 0;
  - timing is unchanged (same wait states).
- When undefined, rsp_err is constant 0, addr[1:0] is ignored, and no alignment logic exists.

Decomposition:
- Package dmem_pkg holds:
  - state enum (IDLE, WAIT, RESP), 2 bits;
  - constant WORD_W = 32 and BE_W = 4;
  - function be_merge(old, new, be) returning the merged word.
- One sub-module, dmem_ram: single-port synchronous RAM with DEPTH words and byte write enables. The read result is registered on the same edge as the access.

Test Plan:
- Reset then idle: assert rst for 2 cycles → req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Full-word store then load:
  - store addr 0x010, wdata 0xDEADBEEF, be 1111, rsp_ready = 1 → rsp_valid exactly 3 cycles after accept, rsp_rdata = 0;
  - load addr 0x010 → rsp_rdata = 0xDEADBEEF.
- Byte-enable merge: store 0x11223344 to 0x020 with be 1111, then 0xAABBCCDD with be 0101, then load → 0x11BB33DD.
- Response backpressure:
  - load with rsp_ready = 0 for 5 cycles → rsp_valid and rsp_rdata held stable and req_ready = 0 throughout;
  - raise rsp_ready → back to IDLE next cycle.
- Reset in WAIT: accept store 0x12345678 to 0x030 (RAM held 0) and pulse rst in the cycle after accept → a later load of 0x030 returns 0.
- With DMEM_ALIGN_CHECK_EN: store to 0x041 → rsp_err = 1 with normal latency; a load of 0x040 returns the prior value unchanged.
